score_seg_display: RTL
======================

Name: score_seg_display

Overview:
- Downstream consumer of the 8-bit score PIO output (out_port of the score register).
- Converts the unsigned binary score to 3-digit BCD with a sequential double-dabble FSM.
- Drives three active-low 7-segment digits with leading-zero blanking.
- Pulses `update` whenever a new value has been displayed; one instance per player score.

Parameters:
- FLASH_HALF, 12500000, clocks per on/off phase of the update flash (used only with SCORE_FLASH_EN).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- score  in  8  unsigned score from the PIO out_port; may change on any cycle
- bcd  out  12  {hundreds, tens, ones}, registered
- seg0  out  7  ones digit, active-low, bit6=g .. bit0=a
- seg1  out  7  tens digit, active-low
- seg2  out  7  hundreds digit, active-low
- busy  out  1  high while the FSM is not IDLE
- update  out  1  one-cycle pulse when bcd and seg are reloaded

Behaviour:
- Reset values:
  - Input sample s_q=0, conv_src=0, bcd=12'h000, update=0, busy=0, state=IDLE.
  - seg0=7'b1000000 ("0"); seg1=seg2=7'b1111111 (blank).
- Input sampling: s_q<=score every clock.
- IDLE:
  - If s_q!=conv_src, go to CONV at the next edge.
  - On that edge: sh<={12'b0,s_q}, conv_src<=s_q, cnt<=0.
  - Otherwise stay in IDLE.
- CONV:
  - Each clock, every BCD nibble of sh[19:8] that is >=5 gets +3 (4-bit add, no carry out).
  - The adjusted 20-bit vector is then shifted left by 1, and cnt increments.
  - After the 8th shift (cnt==7 on that edge), go to DONE.
- DONE:
  - At the next edge, bcd<=sh[19:8] and seg0..seg2 are loaded from the encoder.
  - At the same edge, update=1 for exactly one cycle and the FSM returns to IDLE.
- busy=1 in CONV and DONE, 0 in IDLE.
- Latency: the IDLE decision edge counts as edge 0 (the edge after s_q captured a new value). Entry to CONV is at edge 1; the shifts occur at edges 2..9; bcd and seg update at edge 10.
- Digit encoding, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking:
  - seg2 is blank when hundreds==0.
  - seg1 is blank when hundreds==0 and tens==0.
  - seg0 is never blank.
- Score change while busy: the change is ignored until IDLE. IDLE then sees the mismatch and starts a new conversion, so the last stable value always wins and no intermediate value is required.
- Score returning to conv_src before IDLE: no new conversion starts.
- Reset asserted mid-conversion: all state returns immediately to reset values, with no update pulse.
- Range: the maximum score of 255 produces 12'h255. Overflow is impossible because 3 digits suffice.

Optional Feature:
- SCORE_FLASH_EN defined:
  - Each update starts a flash sequence of 6 phases of FLASH_HALF clocks each: off, on, off, on, off, on.
  - During "off" phases seg0..seg2 output 7'b1111111. bcd is unaffected.
  - A new update during a flash restarts the sequence at phase 0.
  - Reset clears the flash counter with display on.
- SCORE_FLASH_EN undefined:
  - No flash logic; segments always show the encoded bcd.
  - FLASH_HALF is unused.

Test Plan:
- Reset check → bcd=000, seg0=1000000, seg1=seg2=1111111, busy=0, update=0; outputs hold while score stays 0.
- score=42 held → update pulses exactly 10 clocks after the IDLE decision edge; bcd=12'h042, seg0=0100100, seg1=0011001, seg2=1111111.
- score=255, then 7 → bcd=12'h255 with seg2=0100100, seg1=0010010, seg0=0010010; then bcd=12'h007 with seg1 and seg2 blank.
- score 10→11 at the 3rd CONV cycle → the first conversion completes with bcd=010, then a second conversion yields bcd=011; exactly two update pulses.
- reset_n low during CONV of score=99 → outputs return to reset values immediately with no update; after release with score=99 held, bcd=099 after a fresh 10-clock conversion.
- SCORE_FLASH_EN with FLASH_HALF=4, score 5 → 6:
  - Segments are blank for 4 clocks, show "6" for 4, and repeat for 24 clocks total, then stay on.
  - A score change at clock 10 restarts the blank phase after its update.

Source files
------------

// File: rtl/score_seg_display.sv
// score_seg_display: turns the 8-bit score register value into three
// active-low 7-segment digits with leading-zero blanking.
//
// The score is sampled every clock. When the sampled value differs from the
// last converted value and the converter is idle, a sequential double-dabble
// conversion runs (8 shift steps). The result is then loaded into bcd and
// the segment outputs, and update pulses for one cycle.
//
// Optional feature (compile-time macro SCORE_FLASH_EN):
//   When defined, every update starts a flash sequence of six phases of
//   FLASH_HALF clocks each (off, on, off, on, off, on). During the off
//   phases seg0..seg2 are blank. bcd is not affected. When undefined the
//   segments always show the encoded bcd, and FLASH_HALF is unused.
//
// Ports:
//   clk      in   1   system clock
//   reset_n  in   1   asynchronous, active-low reset
//   score    in   8   unsigned score, may change on any cycle
//   bcd      out  12  {hundreds, tens, ones}, registered
//   seg0     out  7   ones digit, active-low, bit6=g .. bit0=a
//   seg1     out  7   tens digit, active-low
//   seg2     out  7   hundreds digit, active-low
//   busy     out  1   high while a conversion is in progress
//   update   out  1   one-cycle pulse when bcd and segments are reloaded

module score_seg_display #(
    parameter int unsigned FLASH_HALF = 12500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  score,
    output logic [11:0] bcd,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic        busy,
    output logic        update
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low g..a pattern for one decimal digit; non-decimal codes blank.
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Three digits with leading-zero blanking; the ones digit always shows.
    function automatic logic [20:0] display_segs(input logic [11:0] b);
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
        s2 = (b[11:8] == 4'd0) ? SEG_BLANK : digit_seg(b[11:8]);
        s1 = (b[11:8] == 4'd0 && b[7:4] == 4'd0) ? SEG_BLANK : digit_seg(b[7:4]);
        s0 = digit_seg(b[3:0]);
        return {s2, s1, s0};
    endfunction

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[8 + 4*i +: 4] >= 4'd5) begin
                a[8 + 4*i +: 4] = a[8 + 4*i +: 4] + 4'd3;
            end
        end
        return {a[18:0], 1'b0};
    endfunction

    state_t      state;
    logic [7:0]  s_q;
    logic [7:0]  conv_src;
    logic [19:0] sh;
    logic [2:0]  cnt;
    logic [20:0] segs_c;

    assign segs_c = display_segs(sh[19:8]);

    // Input sampling and the conversion FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            s_q      <= 8'd0;
            conv_src <= 8'd0;
            sh       <= 20'd0;
            cnt      <= 3'd0;
            bcd      <= 12'h000;
            busy     <= 1'b0;
            update   <= 1'b0;
        end else begin
            s_q    <= score;
            update <= 1'b0;
            case (state)
                IDLE: begin
                    // Changes seen while busy are picked up here, so the
                    // last stable value always ends up displayed.
                    if (s_q != conv_src) begin
                        sh       <= {12'd0, s_q};
                        conv_src <= s_q;
                        cnt      <= 3'd0;
                        state    <= CONV;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    sh  <= dabble_step(sh);
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd    <= sh[19:8];
                    update <= 1'b1;
                    state  <= IDLE;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCORE_FLASH_EN

    localparam int unsigned FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [FLASH_W-1:0] fl_cnt;
    logic [FLASH_W-1:0] fl_cnt_nx;
    logic [2:0]         fl_phase;
    logic [2:0]         fl_phase_nx;
    logic               fl_active;
    logic               fl_active_nx;
    logic               blank_nx;
    logic [20:0]        enc;
    logic [20:0]        enc_nx;
    logic               load_c;

    assign load_c = (state == DONE);

    // Next flash state; a fresh load restarts the sequence at phase 0.
    always_comb begin
        fl_cnt_nx    = fl_cnt;
        fl_phase_nx  = fl_phase;
        fl_active_nx = fl_active;
        enc_nx       = enc;
        if (load_c) begin
            fl_cnt_nx    = '0;
            fl_phase_nx  = 3'd0;
            fl_active_nx = 1'b1;
            enc_nx       = segs_c;
        end else if (fl_active) begin
            if (fl_cnt == FLASH_W'(FLASH_HALF - 1)) begin
                fl_cnt_nx = '0;
                if (fl_phase == 3'd5) begin
                    fl_active_nx = 1'b0;
                end else begin
                    fl_phase_nx = fl_phase + 3'd1;
                end
            end else begin
                fl_cnt_nx = fl_cnt + FLASH_W'(1);
            end
        end
        // Even phases are the "off" halves of the flash.
        blank_nx = fl_active_nx && !fl_phase_nx[0];
    end

    // Flash counters, held digit patterns and the gated segment outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fl_cnt    <= '0;
            fl_phase  <= 3'd0;
            fl_active <= 1'b0;
            enc       <= {SEG_BLANK, SEG_BLANK, SEG_ZERO};
            seg0      <= SEG_ZERO;
            seg1      <= SEG_BLANK;
            seg2      <= SEG_BLANK;
        end else begin
            fl_cnt    <= fl_cnt_nx;
            fl_phase  <= fl_phase_nx;
            fl_active <= fl_active_nx;
            enc       <= enc_nx;
            seg2      <= blank_nx ? SEG_BLANK : enc_nx[20:14];
            seg1      <= blank_nx ? SEG_BLANK : enc_nx[13:7];
            seg0      <= blank_nx ? SEG_BLANK : enc_nx[6:0];
        end
    end

`else

    // Segment outputs reload together with bcd at the end of a conversion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg0 <= SEG_ZERO;
            seg1 <= SEG_BLANK;
            seg2 <= SEG_BLANK;
        end else if (state == DONE) begin
            seg2 <= segs_c[20:14];
            seg1 <= segs_c[13:7];
            seg0 <= segs_c[6:0];
        end
    end

`endif

endmodule
